// File: rtl/shift_sub_divider_pkg.sv
// Shared constants for the sequential arithmetic units. The multiplier
// controller uses the same state encodings.
package shift_sub_divider_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int STATE_REG_DEF  = 4;
    localparam int STATE_W        = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 4'd0,
        CALC = 4'd1,
        DONE = 4'd2
    } state_e;
endpackage

// File: rtl/shift_sub_div_controller.sv
// Divider control FSM. It owns the iteration counter and decodes the
// load, shift and last-iteration enables that drive the top-level datapath.
module shift_sub_div_controller
    import shift_sub_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_start,
    input  logic   i_div_zero,
    output state_e o_state,
    output logic   o_busy,
    output logic   o_done,
    output logic   o_load,
    output logic   o_shift,
    output logic   o_last
);
    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Iteration counter: loaded on an accepted start, counts down once per shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_cnt <= '0;
        else if (o_load)  r_cnt <= CNT_W'(DATA_WIDTH);
        else if (o_shift) r_cnt <= r_cnt - CNT_W'(1);
    end

    // Next-state and enable decode. Unused encodings fall back to IDLE.
    always_comb begin
        w_next  = r_state;
        o_load  = 1'b0;
        o_shift = 1'b0;
        o_last  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    o_load = 1'b1;
                    w_next = i_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                o_shift = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    o_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_state = r_state;
    assign o_busy  = (r_state != IDLE);
endmodule

// File: rtl/shift_sub_divider.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock.
// Holds the R/Q/M datapath and subtractor; sequencing lives in the controller.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STATE_REG  = STATE_REG_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [STATE_REG-1:0]  p_STATE
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH:0]     r_r;
    logic [DATA_WIDTH-1:0]   r_q;
    logic [DATA_WIDTH-1:0]   r_m;

    state_e                  w_state;
    logic                    w_load;
    logic                    w_shift;
    logic                    w_last;
    logic                    w_div_zero;
    logic [2*DATA_WIDTH:0]   w_rq_shift;
    logic [DATA_WIDTH:0]     w_r_shift;
    logic [DATA_WIDTH:0]     w_trial;
    logic [DATA_WIDTH:0]     w_r_next;
    logic [DATA_WIDTH-1:0]   w_q_next;

    shift_sub_div_controller #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_ctrl (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (start),
        .i_div_zero (w_div_zero),
        .o_state    (w_state),
        .o_busy     (busy),
        .o_done     (done),
        .o_load     (w_load),
        .o_shift    (w_shift),
        .o_last     (w_last)
    );

    assign w_div_zero = (divisor == '0);

    // One restoring step: shift {R,Q} left, trial-subtract M, keep or restore.
    // The trial MSB is the borrow; clear means the subtraction fits.
    assign w_rq_shift = {r_r, r_q} << 1;
    assign w_r_shift  = w_rq_shift[2*DATA_WIDTH:DATA_WIDTH];
    assign w_trial    = w_r_shift - {1'b0, r_m};
    assign w_r_next   = w_trial[DATA_WIDTH] ? w_r_shift : w_trial;
    assign w_q_next   = w_rq_shift[DATA_WIDTH-1:0]
                      | {{(DATA_WIDTH-1){1'b0}}, ~w_trial[DATA_WIDTH]};

    // Working registers: loaded on accepted start, stepped each CALC cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_r <= '0;
            r_q <= '0;
            r_m <= '0;
        end else if (w_load) begin
            r_r <= '0;
            r_q <= dividend;
            r_m <= divisor;
        end else if (w_shift) begin
            r_r <= w_r_next;
            r_q <= w_q_next;
        end
    end

    // Result registers change only on completion (normal or zero divisor).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (w_load && w_div_zero) begin
            quotient  <= '1;
            remainder <= dividend;
        end else if (w_last) begin
            quotient  <= w_q_next;
            remainder <= w_r_next[DATA_WIDTH-1:0];
        end
    end

    // Error flag describes the most recent accepted operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    div_by_zero <= 1'b0;
        else if (w_load) div_by_zero <= w_div_zero;
    end

    assign p_STATE = STATE_REG'(w_state);
endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider: vector table plus hand-written
// sequences for start-while-busy, mid-operation reset and back-to-back runs.
module tb_shift_sub_divider;
    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic [DW-1:0] quotient, remainder;
    logic          busy, done, div_by_zero;
    logic [3:0]    p_STATE;

    shift_sub_divider #(.DATA_WIDTH(DW), .STATE_REG(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .p_STATE     (p_STATE)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int cyc = 0;
    int prev_q = 0;

    always @(posedge i_clk) cyc++;
    always @(negedge i_clk) if (done) done_cnt++;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int lat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one op; latency counts clock edges from the start edge (inclusive)
    // to the negedge where done is first seen.
    task automatic run_op(input int a, input int b, output int lat);
        logic got;
        @(negedge i_clk);
        dividend = DW'(a);
        divisor  = DW'(b);
        start    = 1'b1;
        @(posedge i_clk);
        #1 start = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (k == 0) begin
                chk("result_hold_q", int'(quotient), prev_q);
                chk("state_calc", int'(p_STATE), 1);
            end
            lat++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done for %0d/%0d", a, b);
        end
    endtask

    vec_t vecs[7];
    int lat;
    int d0;
    int n;
    int dcyc[3];

    initial begin
        vecs[0] = '{100, 7,  14,  2,   0, 9};
        vecs[1] = '{255, 1,  255, 0,   0, 9};
        vecs[2] = '{5,   9,  0,   5,   0, 9};
        vecs[3] = '{200, 0,  255, 200, 1, 1};
        vecs[4] = '{9,   3,  3,   0,   0, 9};
        vecs[5] = '{255, 255, 1,  0,   0, 9};
        vecs[6] = '{100, 7,  14,  2,   0, 9};

        // Reset state
        #12;
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_state", int'(p_STATE), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Table-driven operations
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_quotient", i), int'(quotient), vecs[i].q);
            chk($sformatf("v%0d_remainder", i), int'(remainder), vecs[i].r);
            chk($sformatf("v%0d_dbz", i), int'(div_by_zero), vecs[i].dbz);
            chk($sformatf("v%0d_state_done", i), int'(p_STATE), 2);
            @(negedge i_clk);
            chk($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
            chk($sformatf("v%0d_idle", i), int'(busy), 0);
            prev_q = vecs[i].q;
        end

        // start pulses during CALC of 100/7 must be ignored
        @(posedge i_clk);
        d0 = done_cnt;
        @(negedge i_clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge i_clk);
        #1 start = 1'b0;
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (done) break;
            start = 1'b0;
            if (lat == 3 || lat == 7) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            lat++;
        end
        start = 1'b0;
        chk("busy_start_latency", lat, 9);
        chk("busy_start_quotient", int'(quotient), 14);
        chk("busy_start_remainder", int'(remainder), 2);
        repeat (4) @(posedge i_clk);
        chk("busy_start_done_count", done_cnt - d0, 1);
        chk("busy_start_idle", int'(busy), 0);

        // Asynchronous reset at iteration 4 of 255/16
        @(negedge i_clk);
        dividend = 8'd255;
        divisor  = 8'd16;
        start    = 1'b1;
        @(posedge i_clk);
        #1 start = 1'b0;
        repeat (4) @(negedge i_clk);
        d0 = done_cnt;
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_quotient", int'(quotient), 0);
        chk("mid_rst_remainder", int'(remainder), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_state", int'(p_STATE), 0);
        repeat (8) @(posedge i_clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        prev_q = 0;
        run_op(255, 16, lat);
        chk("post_rst_latency", lat, 9);
        chk("post_rst_quotient", int'(quotient), 15);
        chk("post_rst_remainder", int'(remainder), 15);
        chk("post_rst_dbz", int'(div_by_zero), 0);
        repeat (3) @(negedge i_clk);

        // Back-to-back with start held high: 77/10 three times
        @(negedge i_clk);
        dividend = 8'd77;
        divisor  = 8'd10;
        start    = 1'b1;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge i_clk);
            if (done) begin
                dcyc[n] = cyc;
                chk($sformatf("b2b%0d_quotient", n), int'(quotient), 7);
                chk($sformatf("b2b%0d_remainder", n), int'(remainder), 7);
                n++;
                if (n == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_done_count", n, 3);
        if (n == 3) begin
            chk("b2b_spacing_1", dcyc[1] - dcyc[0], 10);
            chk("b2b_spacing_2", dcyc[2] - dcyc[1], 10);
        end
        repeat (3) @(negedge i_clk);
        chk("b2b_final_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
